// File: rtl/pcm_mem_reader.sv
// Purpose: Avalon-MM read master fetching a contiguous word block and streaming it out on valid/ready.
// Latency: first st_valid 3 cycles after start with a 1-cycle slave; sustains 1 word/clk.
// Backpressure: reads issue only while pend + fifo_count < FIFO_DEPTH, so a stalled consumer never overruns the FIFO.
module pcm_mem_reader #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_PEND   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_last
);
    localparam int PW = $clog2(MAX_PEND + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int LW = ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LW-1:0]     remain_q, remain_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     dcnt_q, dcnt_d;
    logic [PW-1:0]     pend_q, pend_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FW-1:0]     wptr_q, wptr_d;
    logic [FW-1:0]     rptr_q, rptr_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic issue_ok;
    logic accept;
    logic ret;
    logic push;
    logic pop;

    // Bus and stream outputs; the issue condition can only grow more permissive during a stall,
    // so avm_read/avm_address stay stable while waitrequest is high.
    always_comb begin
        issue_ok = (remain_q != '0)
                && (int'(pend_q) < MAX_PEND)
                && (int'(pend_q) + int'(cnt_q) < FIFO_DEPTH);
        avm_read = ((state_q == S_RUN) && issue_ok) || ((state_q == S_FLUSH) && hold_q);
        accept   = avm_read && !avm_waitrequest;
        ret      = avm_readdatavalid && (state_q != S_IDLE) && (pend_q != '0);
        push     = ret && (state_q == S_RUN);
        st_valid = (state_q == S_RUN) && (cnt_q != '0);
        pop      = st_valid && st_ready;
        st_data  = mem_q[rptr_q];
        st_last  = st_valid && (dcnt_q == len_q - LW'(1));
        busy     = (state_q != S_IDLE);
        done     = done_q;
        avm_address = addr_q;
    end

    // Next-state for the FSM, bus counters and FIFO bookkeeping.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        len_d    = len_q;
        dcnt_d   = dcnt_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        hold_d   = hold_q;
        done_d   = 1'b0;

        if (accept) begin
            addr_d   = addr_q + ADDR_W'(1);
            remain_d = remain_q - LW'(1);
        end
        case ({accept, ret})
            2'b10:   pend_d = pend_q + PW'(1);
            2'b01:   pend_d = pend_q - PW'(1);
            default: pend_d = pend_q;
        endcase
        if (push) begin
            wptr_d = wptr_q + FW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + FW'(1);
            dcnt_d = dcnt_q + LW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = S_RUN;
                        addr_d   = base_addr;
                        remain_d = length;
                        len_d    = length;
                        dcnt_d   = '0;
                        hold_d   = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    // A stalled request stays posted until the slave takes it.
                    state_d = S_FLUSH;
                    hold_d  = avm_read && avm_waitrequest;
                    cnt_d   = '0;
                    wptr_d  = '0;
                    rptr_d  = '0;
                end else if (pop && st_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_FLUSH: begin
                if (accept) begin
                    hold_d = 1'b0;
                end
                if ((pend_q == '0) && !hold_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            len_q    <= '0;
            dcnt_q   <= '0;
            pend_q   <= '0;
            cnt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            len_q    <= len_d;
            dcnt_q   <= dcnt_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= avm_readdata;
        end
    end

    // A push into a full FIFO would mean the issue rule was broken.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(push && !pop && (int'(cnt_q) == FIFO_DEPTH)));
        end
    end
endmodule

// File: tb/tb_pcm_mem_reader.sv
// Testbench for pcm_mem_reader: behavioural Avalon slave plus stream monitor, scenarios checked against
// a word-level model (expected word i = mem[(base+i) mod 4096], last at i = length-1).
`timescale 1ns/1ps
module tb_pcm_mem_reader;
    localparam int MAXP = 4;

    logic        clk = 1'b0;
    logic        reset_n, start, abort, st_ready;
    logic [11:0] base_addr;
    logic [12:0] length;
    logic        busy, done, avm_read, avm_waitrequest, avm_readdatavalid;
    logic [11:0] avm_address;
    logic [31:0] avm_readdata, st_data;
    logic        st_valid, st_last;

    pcm_mem_reader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
        .abort(abort), .busy(busy), .done(done), .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .st_data(st_data), .st_valid(st_valid),
        .st_ready(st_ready), .st_last(st_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // slave configuration, written by the scenario tasks
    int wr_mode    = 0;   // 0 never stall, 1 random 50 %, 2 always stall
    int lat_min    = 1;
    int lat_max    = 1;
    bit pat        = 1'b0;
    bit inject_rdv = 1'b0;

    typedef struct { logic [11:0] a; logic [31:0] d; int rdy; } req_t;
    req_t        req_q[$];
    int          last_rdy = 0;
    logic [11:0] acc_a[$];
    int          acc_c[$];
    logic [31:0] got_d[$];
    bit          got_l[$];
    int          got_c[$];
    int          done_c[$];
    int          done_busy = 0;

    function automatic logic [31:0] mem_val(input logic [11:0] a, input bit p);
        if (!p) return {20'h0, a};
        return {a[7:0], a[11:4] ^ 8'h3C, 4'hA, a};
    endfunction

    function automatic logic [31:0] exp_word(input logic [11:0] b, input int i, input bit p);
        logic [11:0] a;
        a = b + 12'(i);
        return mem_val(a, p);
    endfunction

    // Slave model and stream monitor: observe at negedge, drive just after posedge.
    initial begin : env
        bit          prev_stall;
        logic [11:0] prev_addr;
        bit          prev_sstall;
        logic [31:0] prev_sdata;
        req_t        r;
        int          lat;
        prev_stall = 1'b0; prev_addr = '0; prev_sstall = 1'b0; prev_sdata = '0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                n_checks++;
                if (!avm_read || avm_address !== prev_addr) begin
                    n_fail++;
                    $display("FAIL stall_hold: read=%0b addr=%h, required read=1 addr=%h", avm_read, avm_address, prev_addr);
                end
            end
            prev_stall = reset_n && avm_read && avm_waitrequest;
            prev_addr  = avm_address;
            if (avm_read && !avm_waitrequest) begin
                lat   = int'($urandom_range(lat_max, lat_min));
                r.a   = avm_address;
                r.d   = mem_val(avm_address, pat);
                r.rdy = (cyc + lat > last_rdy) ? cyc + lat : last_rdy + 1;
                last_rdy = r.rdy;
                req_q.push_back(r);
                acc_a.push_back(avm_address);
                acc_c.push_back(cyc);
            end
            if (req_q.size() > 0) begin
                n_checks++;
                if (req_q.size() > MAXP) begin
                    n_fail++;
                    $display("FAIL pend_limit: outstanding=%0d, required <= %0d", req_q.size(), MAXP);
                end
            end
            if (prev_sstall) begin
                n_checks++;
                if (!st_valid || st_data !== prev_sdata) begin
                    n_fail++;
                    $display("FAIL st_hold: valid=%0b data=%h, required valid=1 data=%h", st_valid, st_data, prev_sdata);
                end
            end
            prev_sstall = reset_n && !abort && st_valid && !st_ready;
            prev_sdata  = st_data;
            if (st_valid && st_ready) begin
                got_d.push_back(st_data); got_l.push_back(st_last); got_c.push_back(cyc);
            end
            if (done) begin
                done_c.push_back(cyc);
                if (busy) done_busy++;
            end
            @(posedge clk);
            cyc++;
            #1;
            if (req_q.size() > 0 && req_q[0].rdy <= cyc) begin
                r = req_q.pop_front();
                avm_readdatavalid = 1'b1;
                avm_readdata      = r.d;
            end else begin
                avm_readdatavalid = inject_rdv;
                avm_readdata      = $urandom;
            end
            avm_waitrequest = (wr_mode == 2) ? 1'b1 : (wr_mode == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
        end
    end

    task automatic clear_logs();
        acc_a.delete(); acc_c.delete(); got_d.delete(); got_l.delete(); got_c.delete();
        done_c.delete(); done_busy = 0;
    endtask

    task automatic do_start(input logic [11:0] b, input logic [12:0] l, output int sc);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; length = l; sc = cyc;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 12'($urandom); length = 13'($urandom);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; st_ready = 1'b1; base_addr = '0; length = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL rst_done: got %b, required 0", done); end
        n_checks++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL rst_read: got %b, required 0", avm_read); end
        n_checks++; if (st_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", st_valid); end
        n_checks++; if (st_last !== 1'b0)  begin n_fail++; $display("FAIL rst_last: got %b, required 0", st_last); end
        n_checks++; if (avm_address !== 12'h0) begin n_fail++; $display("FAIL rst_addr: got %h, required 000", avm_address); end
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int sc; bit ok;
        pat = 1'b0; wr_mode = 0; lat_min = 1; lat_max = 1; st_ready = 1'b1;
        clear_logs();
        do_start(12'h010, 13'd4, sc);
        wait_idle(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: busy stuck, required idle within 100 cycles"); end
        n_checks++; if (acc_a.size() != 4) begin n_fail++; $display("FAIL basic_nreads: got %0d, required 4", acc_a.size()); end
        for (int i = 0; i < acc_a.size() && i < 4; i++) begin
            n_checks++; if (acc_a[i] !== 12'h010 + 12'(i) || acc_c[i] != sc + 1 + i) begin n_fail++;
                $display("FAIL basic_addr[%0d]: got %h@%0d, required %h@%0d", i, acc_a[i], acc_c[i], 12'h010 + 12'(i), sc + 1 + i); end
        end
        n_checks++; if (got_d.size() != 4) begin n_fail++; $display("FAIL basic_nwords: got %0d, required 4", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 4; i++) begin
            n_checks++; if (got_d[i] !== exp_word(12'h010, i, 1'b0) || got_l[i] != (i == 3) || got_c[i] != sc + 3 + i) begin n_fail++;
                $display("FAIL basic_word[%0d]: got %h last=%0b @%0d, required %h last=%0b @%0d", i, got_d[i], got_l[i], got_c[i],
                         exp_word(12'h010, i, 1'b0), (i == 3), sc + 3 + i); end
        end
        n_checks++; if (done_c.size() != 1 || done_c[0] != sc + 7) begin n_fail++;
            $display("FAIL basic_done: got %0d pulses first@%0d, required 1 @%0d", done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, sc + 7); end
        n_checks++; if (done_busy != 0) begin n_fail++; $display("FAIL basic_done_busy: busy high with done %0d times, required 0", done_busy); end
    endtask

    task automatic test_wrap();
        int sc; bit ok;
        pat = 1'b1; clear_logs();
        do_start(12'hFFE, 13'd4, sc);
        wait_idle(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout: busy stuck, required idle within 100 cycles"); end
        n_checks++; if (acc_a.size() != 4 || got_d.size() != 4) begin n_fail++;
            $display("FAIL wrap_count: reads=%0d words=%0d, required 4/4", acc_a.size(), got_d.size()); end
        for (int i = 0; i < acc_a.size() && i < 4; i++) begin
            n_checks++; if (acc_a[i] !== 12'hFFE + 12'(i)) begin n_fail++;
                $display("FAIL wrap_addr[%0d]: got %h, required %h", i, acc_a[i], 12'hFFE + 12'(i)); end
        end
        for (int i = 0; i < got_d.size() && i < 4; i++) begin
            n_checks++; if (got_d[i] !== exp_word(12'hFFE, i, 1'b1) || got_l[i] != (i == 3)) begin n_fail++;
                $display("FAIL wrap_word[%0d]: got %h last=%0b, required %h last=%0b", i, got_d[i], got_l[i], exp_word(12'hFFE, i, 1'b1), (i == 3)); end
        end
        n_checks++; if (done_c.size() != 1) begin n_fail++; $display("FAIL wrap_done: got %0d pulses, required 1", done_c.size()); end
    endtask

    task automatic test_backpressure();
        int sc; bit ok; logic [11:0] b;
        b = 12'($urandom); pat = 1'b1; st_ready = 1'b0; clear_logs();
        do_start(b, 13'd20, sc);
        repeat (30) @(negedge clk);
        n_checks++; if (acc_a.size() != 8) begin n_fail++; $display("FAIL bp_reads_stalled: got %0d, required 8", acc_a.size()); end
        n_checks++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL bp_read_low: got %b, required 0", avm_read); end
        n_checks++; if (st_valid !== 1'b1 || got_d.size() != 0) begin n_fail++;
            $display("FAIL bp_held: valid=%b words=%0d, required valid=1 words=0", st_valid, got_d.size()); end
        @(posedge clk); #1 st_ready = 1'b1;
        wait_idle(200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: busy stuck, required idle within 200 cycles"); end
        n_checks++; if (got_d.size() != 20 || acc_a.size() != 20) begin n_fail++;
            $display("FAIL bp_count: words=%0d reads=%0d, required 20/20", got_d.size(), acc_a.size()); end
        for (int i = 0; i < got_d.size() && i < 20; i++) begin
            n_checks++; if (got_d[i] !== exp_word(b, i, 1'b1) || got_l[i] != (i == 19)) begin n_fail++;
                $display("FAIL bp_word[%0d]: got %h last=%0b, required %h last=%0b", i, got_d[i], got_l[i], exp_word(b, i, 1'b1), (i == 19)); end
        end
        n_checks++; if (done_c.size() != 1) begin n_fail++; $display("FAIL bp_done: got %0d pulses, required 1", done_c.size()); end
    endtask

    task automatic test_random();
        int sc; bit ok; logic [11:0] b;
        b = 12'($urandom); pat = 1'b1; wr_mode = 1; lat_min = 1; lat_max = 3; clear_logs();
        do_start(b, 13'd64, sc);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            st_ready = ($urandom_range(3, 0) != 0);
            if (!busy) begin ok = 1'b1; break; end
        end
        st_ready = 1'b1; wr_mode = 0; lat_min = 1; lat_max = 1;
        repeat (3) @(negedge clk);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_timeout: busy stuck, required idle within 3000 cycles"); end
        n_checks++; if (got_d.size() != 64 || acc_a.size() != 64) begin n_fail++;
            $display("FAIL rand_count: words=%0d reads=%0d, required 64/64", got_d.size(), acc_a.size()); end
        for (int i = 0; i < acc_a.size() && i < 64; i++) begin
            n_checks++; if (acc_a[i] !== b + 12'(i)) begin n_fail++; $display("FAIL rand_addr[%0d]: got %h, required %h", i, acc_a[i], b + 12'(i)); end
        end
        for (int i = 0; i < got_d.size() && i < 64; i++) begin
            n_checks++; if (got_d[i] !== exp_word(b, i, 1'b1) || got_l[i] != (i == 63)) begin n_fail++;
                $display("FAIL rand_word[%0d]: got %h last=%0b, required %h last=%0b", i, got_d[i], got_l[i], exp_word(b, i, 1'b1), (i == 63)); end
        end
        n_checks++; if (done_c.size() != 1) begin n_fail++; $display("FAIL rand_done: got %0d pulses, required 1", done_c.size()); end
    endtask

    task automatic test_abort();
        int sc; bit ok; bit rd_low;
        pat = 1'b0; wr_mode = 0; st_ready = 1'b1; clear_logs();
        do_start(12'h040, 13'd100, sc);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        rd_low = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (!avm_read) begin rd_low = 1'b1; break; end
        end
        n_checks++; if (!rd_low) begin n_fail++; $display("FAIL abort_read_drop: avm_read still 1 after 2 cycles, required 0"); end
        wait_idle(50, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_timeout: busy stuck, required idle within 50 cycles"); end
        n_checks++; if (acc_a.size() != 2) begin n_fail++; $display("FAIL abort_nreads: got %0d, required 2", acc_a.size()); end
        n_checks++; if (got_d.size() != 0) begin n_fail++; $display("FAIL abort_stream: got %0d words, required 0", got_d.size()); end
        n_checks++; if (done_c.size() != 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses, required 0", done_c.size()); end
        n_checks++; if (req_q.size() != 0) begin n_fail++; $display("FAIL abort_drain: %0d reads outstanding at idle, required 0", req_q.size()); end
        // abort while a request is stalled: it must stay posted until accepted
        clear_logs(); wr_mode = 2;
        do_start(12'h200, 13'd50, sc);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 wr_mode = 0;
        wait_idle(50, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_stall_timeout: busy stuck, required idle within 50 cycles"); end
        n_checks++; if (acc_a.size() != 1 || (acc_a.size() > 0 && acc_a[0] !== 12'h200)) begin n_fail++;
            $display("FAIL abort_stall_reads: got %0d reads first=%h, required 1 read at 200", acc_a.size(), (acc_a.size() > 0) ? acc_a[0] : 12'h0); end
        n_checks++; if (got_d.size() != 0 || done_c.size() != 0) begin n_fail++;
            $display("FAIL abort_stall_out: words=%0d done=%0d, required 0/0", got_d.size(), done_c.size()); end
        // a fresh transfer after the abort
        clear_logs();
        do_start(12'h123, 13'd5, sc);
        wait_idle(100, ok);
        n_checks++; if (!ok || got_d.size() != 5 || done_c.size() != 1) begin n_fail++;
            $display("FAIL abort_restart: idle=%0b words=%0d done=%0d, required 1/5/1", ok, got_d.size(), done_c.size()); end
        for (int i = 0; i < got_d.size() && i < 5; i++) begin
            n_checks++; if (got_d[i] !== exp_word(12'h123, i, 1'b0)) begin n_fail++;
                $display("FAIL abort_restart_word[%0d]: got %h, required %h", i, got_d[i], exp_word(12'h123, i, 1'b0)); end
        end
    endtask

    task automatic test_len0();
        int sc;
        clear_logs();
        do_start(12'($urandom), 13'd0, sc);
        repeat (4) @(negedge clk);
        n_checks++; if (acc_a.size() != 0) begin n_fail++; $display("FAIL len0_reads: got %0d, required 0", acc_a.size()); end
        n_checks++; if (done_c.size() != 1 || done_c[0] != sc + 1) begin n_fail++;
            $display("FAIL len0_done: got %0d pulses first@%0d, required 1 @%0d", done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, sc + 1); end
        n_checks++; if (done_busy != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy: busy was high, required 0"); end
    endtask

    task automatic test_reset_mid();
        int sc; bit ok;
        pat = 1'b1; lat_min = 3; lat_max = 3; st_ready = 1'b1; clear_logs();
        do_start(12'h300, 13'd30, sc);
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1; inject_rdv = 1'b1; clear_logs();
        @(negedge clk);
        n_checks++; if ({busy, done, avm_read, st_valid, st_last} !== 5'b0 || avm_address !== 12'h0) begin n_fail++;
            $display("FAIL midrst_outputs: busy=%b done=%b read=%b valid=%b last=%b addr=%h, required all 0",
                     busy, done, avm_read, st_valid, st_last, avm_address); end
        @(posedge clk); @(posedge clk); #1 inject_rdv = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++; if (acc_a.size() != 0 || got_d.size() != 0) begin n_fail++;
            $display("FAIL midrst_quiet: reads=%0d words=%0d, required 0/0", acc_a.size(), got_d.size()); end
        n_checks++; if (busy !== 1'b0 || done_c.size() != 0) begin n_fail++;
            $display("FAIL midrst_idle: busy=%b done=%0d, required 0/0", busy, done_c.size()); end
        lat_min = 1; lat_max = 1; clear_logs();
        do_start(12'h7F0, 13'd6, sc);
        wait_idle(100, ok);
        n_checks++; if (!ok || got_d.size() != 6 || acc_a.size() != 6 || done_c.size() != 1) begin n_fail++;
            $display("FAIL midrst_restart: idle=%0b words=%0d reads=%0d done=%0d, required 1/6/6/1", ok, got_d.size(), acc_a.size(), done_c.size()); end
        for (int i = 0; i < got_d.size() && i < 6; i++) begin
            n_checks++; if (got_d[i] !== exp_word(12'h7F0, i, 1'b1) || got_l[i] != (i == 5)) begin n_fail++;
                $display("FAIL midrst_word[%0d]: got %h last=%0b, required %h last=%0b", i, got_d[i], got_l[i], exp_word(12'h7F0, i, 1'b1), (i == 5)); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_random();
        test_abort();
        test_len0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
